addsub_pre_norm_pipe: RTL and testbench

ADDSUB_PRE_NORM_PIPE -- requirements
Module: addsub_pre_norm_pipe

---
 rtl/addsub_pre_norm_pipe_if.sv | 31 +++
 rtl/addsub_pre_norm_pipe.sv | 144 ++++++++++++++
 tb/tb_addsub_pre_norm_pipe.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/addsub_pre_norm_pipe_if.sv
// Handshake and data bundle for the add/subtract pre-normalizer.
// slave = the pipeline, master = the upstream/downstream side driving it.
interface addsub_pre_norm_pipe_if;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        fpu_op_i;
  logic [1:0]  rmode_i;
  logic        valid_i;
  logic        ready_o;
  logic        ready_i;
  logic        valid_o;
  logic [27:0] fract_28_o;
  logic [7:0]  exp_o;
  logic        sign_o;
  logic [31:0] opa_o;
  logic [31:0] opb_o;
  logic        fpu_op_o;
  logic [1:0]  rmode_o;

  modport slave (
    input  opa_i, opb_i, fpu_op_i, rmode_i, valid_i, ready_i,
    output ready_o, valid_o, fract_28_o, exp_o, sign_o,
           opa_o, opb_o, fpu_op_o, rmode_o
  );

  modport master (
    output opa_i, opb_i, fpu_op_i, rmode_i, valid_i, ready_i,
    input  ready_o, valid_o, fract_28_o, exp_o, sign_o,
           opa_o, opb_o, fpu_op_o, rmode_o
  );
endinterface

// File: rtl/addsub_pre_norm_pipe.sv
// Two-stage single-precision add/sub pre-normalizer: S1 unpack/compare/align, S2 add/sub.
// Define ADDSUB_PRE_NORM_DAZ_EN to flush denormal operands to signed zero.
module addsub_pre_norm_pipe (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  addsub_pre_norm_pipe_if.slave        bus
);

  logic advance;
  logic valid_o_reg;

  // The whole pipe moves together; it only stops when the output is blocked.
  assign advance     = !valid_o_reg || bus.ready_i;
  assign bus.ready_o = advance;

  // ---------------- S1: unpack, compare, align ----------------
  logic [31:0] op_in   [2];
  logic [7:0]  eff_exp [2];
  logic [26:0] mant    [2];

  assign op_in[0] = bus.opa_i;
  assign op_in[1] = bus.opb_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      logic [7:0] raw_exp;
      assign raw_exp     = op_in[gi][30:23];
      assign eff_exp[gi] = (raw_exp == 8'd0) ? 8'd1 : raw_exp;
`ifdef ADDSUB_PRE_NORM_DAZ_EN
      assign mant[gi]    = (raw_exp == 8'd0) ? 27'd0 : {1'b1, op_in[gi][22:0], 3'b000};
`else
      assign mant[gi]    = {raw_exp != 8'd0, op_in[gi][22:0], 3'b000};
`endif
    end
  endgenerate

  logic        a_larger;
  logic [26:0] large_mant, small_mant, shifted, lost_mask, aligned_next;
  logic [7:0]  large_exp, small_exp, exp_diff;
  logic [4:0]  shamt;
  logic        sticky, sign_b_eff, sign_next_s1, eff_sub_next;

  always_comb begin
    a_larger   = {eff_exp[0], mant[0]} >= {eff_exp[1], mant[1]};
    large_mant = a_larger ? mant[0] : mant[1];
    small_mant = a_larger ? mant[1] : mant[0];
    large_exp  = a_larger ? eff_exp[0] : eff_exp[1];
    small_exp  = a_larger ? eff_exp[1] : eff_exp[0];
    exp_diff   = large_exp - small_exp;
    shamt      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
    shifted    = small_mant >> shamt;
    // Bits that fall off the right edge collapse into the sticky position.
    lost_mask  = ~(27'h7FF_FFFF << shamt);
    sticky     = |(small_mant & lost_mask);
    aligned_next = {shifted[26:1], shifted[0] | sticky};
    sign_b_eff   = op_in[1][31] ^ bus.fpu_op_i;
    sign_next_s1 = a_larger ? op_in[0][31] : sign_b_eff;
    eff_sub_next = op_in[0][31] ^ op_in[1][31] ^ bus.fpu_op_i;
  end

  logic        s1_valid_reg, s1_sub_reg, s1_sign_reg, s1_fpu_op_reg;
  logic [26:0] s1_large_reg, s1_small_reg;
  logic [7:0]  s1_exp_reg;
  logic [31:0] s1_opa_reg, s1_opb_reg;
  logic [1:0]  s1_rmode_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_reg  <= 1'b0;
      s1_sub_reg    <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_fpu_op_reg <= 1'b0;
      s1_large_reg  <= '0;
      s1_small_reg  <= '0;
      s1_exp_reg    <= '0;
      s1_opa_reg    <= '0;
      s1_opb_reg    <= '0;
      s1_rmode_reg  <= '0;
    end else if (advance) begin
      s1_valid_reg  <= bus.valid_i;
      s1_sub_reg    <= eff_sub_next;
      s1_sign_reg   <= sign_next_s1;
      s1_fpu_op_reg <= bus.fpu_op_i;
      s1_large_reg  <= large_mant;
      s1_small_reg  <= aligned_next;
      s1_exp_reg    <= large_exp;
      s1_opa_reg    <= bus.opa_i;
      s1_opb_reg    <= bus.opb_i;
      s1_rmode_reg  <= bus.rmode_i;
    end
  end

  // ---------------- S2: add / subtract ----------------
  logic [27:0] fract_next;
  logic        sign_next_s2;

  always_comb begin
    // Large >= aligned small by construction, so the difference never wraps.
    fract_next   = s1_sub_reg ? ({1'b0, s1_large_reg} - {1'b0, s1_small_reg})
                              : ({1'b0, s1_large_reg} + {1'b0, s1_small_reg});
    sign_next_s2 = s1_sign_reg;
    if (s1_sub_reg && fract_next == 28'd0)
      sign_next_s2 = (s1_rmode_reg == 2'b11);
  end

  logic [27:0] fract_reg;
  logic [7:0]  exp_reg;
  logic        sign_reg, fpu_op_o_reg;
  logic [31:0] opa_o_reg, opb_o_reg;
  logic [1:0]  rmode_o_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o_reg  <= 1'b0;
      fract_reg    <= '0;
      exp_reg      <= '0;
      sign_reg     <= 1'b0;
      fpu_op_o_reg <= 1'b0;
      opa_o_reg    <= '0;
      opb_o_reg    <= '0;
      rmode_o_reg  <= '0;
    end else if (advance) begin
      valid_o_reg  <= s1_valid_reg;
      fract_reg    <= fract_next;
      exp_reg      <= s1_exp_reg;
      sign_reg     <= sign_next_s2;
      fpu_op_o_reg <= s1_fpu_op_reg;
      opa_o_reg    <= s1_opa_reg;
      opb_o_reg    <= s1_opb_reg;
      rmode_o_reg  <= s1_rmode_reg;
    end
  end

  assign bus.valid_o    = valid_o_reg;
  assign bus.fract_28_o = fract_reg;
  assign bus.exp_o      = exp_reg;
  assign bus.sign_o     = sign_reg;
  assign bus.opa_o      = opa_o_reg;
  assign bus.opb_o      = opb_o_reg;
  assign bus.fpu_op_o   = fpu_op_o_reg;
  assign bus.rmode_o    = rmode_o_reg;

endmodule

// File: tb/tb_addsub_pre_norm_pipe.sv
// Directed bench for addsub_pre_norm_pipe: single beats, stalled stream, reset mid-flight.
module tb_addsub_pre_norm_pipe;
  logic clk_i = 1'b0;
  logic rst_n_i;
  int   errors = 0;
  int   checks = 0;

  addsub_pre_norm_pipe_if bus ();

  addsub_pre_norm_pipe dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated beat: accept, confirm nothing after one edge, check after two.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [1:0] rm, input logic [27:0] ef,
                         input logic [7:0] ee, input logic es);
    bus.opa_i    = a;
    bus.opb_i    = b;
    bus.fpu_op_i = op;
    bus.rmode_i  = rm;
    bus.valid_i  = 1'b1;
    bus.ready_i  = 1'b1;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    check({tag, ".lat1"}, 32'(bus.valid_o), 32'd0);
    @(posedge clk_i); #1;
    check({tag, ".valid"}, 32'(bus.valid_o), 32'd1);
    check({tag, ".fract"}, 32'(bus.fract_28_o), 32'(ef));
    check({tag, ".exp"},   32'(bus.exp_o), 32'(ee));
    check({tag, ".sign"},  32'(bus.sign_o), 32'(es));
    check({tag, ".opa"},   bus.opa_o, a);
    $display("beat %s: opa=%h opb=%h op=%0d rm=%0d -> fract=%h exp=%h sign=%0d",
             tag, a, b, op, rm, bus.fract_28_o, bus.exp_o, bus.sign_o);
    @(posedge clk_i); #1;
  endtask

  logic [27:0] daz_fract;
  int in_idx, out_idx;
  logic acc, cons;

  initial begin
    rst_n_i      = 1'b1;
    bus.opa_i    = '0;
    bus.opb_i    = '0;
    bus.fpu_op_i = 1'b0;
    bus.rmode_i  = 2'b00;
    bus.valid_i  = 1'b0;
    bus.ready_i  = 1'b1;
    #2 rst_n_i = 1'b0;
    #1;
    check("rst.valid_o", 32'(bus.valid_o), 32'd0);
    check("rst.ready_o", 32'(bus.ready_o), 32'd1);
    check("rst.fract",   32'(bus.fract_28_o), 32'd0);
    check("rst.exp",     32'(bus.exp_o), 32'd0);
    check("rst.sign",    32'(bus.sign_o), 32'd0);
    check("rst.opa",     bus.opa_o, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_n_i = 1'b1;

    // 1.0 + 1.0 = 2.0: hidden bits sum into the carry bit
    run_one("add_1_1",   32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 28'h8000000, 8'h7F, 1'b0);
    run_one("sub_eq_rn", 32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 28'h0000000, 8'h7F, 1'b0);
    run_one("sub_eq_rm", 32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 28'h0000000, 8'h7F, 1'b1);
    // exponent gap 30 clamps to 27; the whole small mantissa becomes sticky
    run_one("add_clamp", 32'h3F800000, 32'h30800000, 1'b0, 2'b00, 28'h4000001, 8'h7F, 1'b0);
    // 2.0 - 1.0 at exponent 80h: 1.0 aligned is 2000000h, difference is 2000000h
    run_one("sub_2_1",   32'h40000000, 32'h3F800000, 1'b1, 2'b00, 28'h2000000, 8'h80, 1'b0);
    run_one("sub_1_2",   32'h3F800000, 32'h40000000, 1'b1, 2'b00, 28'h2000000, 8'h80, 1'b1);
    // 1.0 + (-1.0) is an effective subtract; +inf rounding still yields +0
    run_one("add_neg",   32'h3F800000, 32'hBF800000, 1'b0, 2'b10, 28'h0000000, 8'h7F, 1'b0);

    // Four back-to-back beats, downstream blocked for cycles 3..5.
    in_idx  = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.valid_i  = (in_idx < 4);
      bus.opa_i    = {1'b0, 8'(8'h7F + in_idx), 23'd0};
      bus.opb_i    = {1'b0, 8'(8'h7F + in_idx), 23'd0};
      bus.fpu_op_i = 1'b0;
      bus.rmode_i  = 2'b00;
      bus.ready_i  = !(cyc >= 3 && cyc <= 5);
      @(negedge clk_i);
      acc  = bus.valid_i && bus.ready_o;
      cons = bus.valid_o && bus.ready_i;
      if (bus.valid_o) begin
        check($sformatf("stream.exp%0d", out_idx), 32'(bus.exp_o), 32'(8'h7F + out_idx));
        check($sformatf("stream.fract%0d", out_idx), 32'(bus.fract_28_o), 32'h8000000);
        $display("stream cyc=%0d: exp=%h ready_i=%0d consumed=%0d", cyc, bus.exp_o, bus.ready_i, cons);
      end
      if (cons) out_idx++;
      @(posedge clk_i); #1;
      if (acc) in_idx++;
    end
    check("stream.count", 32'(out_idx), 32'd4);

    // Two beats in flight, then an asynchronous reset.
    bus.opa_i   = 32'h3F800000;
    bus.opb_i   = 32'h3F800000;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.opa_i = 32'h40000000;
    @(posedge clk_i); #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    check("flight.valid_pre", 32'(bus.valid_o), 32'd1);
    #1 rst_n_i = 1'b0;
    #1;
    check("flight.valid_rst", 32'(bus.valid_o), 32'd0);
    check("flight.ready_rst", 32'(bus.ready_o), 32'd1);
    check("flight.fract_rst", 32'(bus.fract_28_o), 32'd0);
    $display("reset in flight: valid_o=%0d ready_o=%0d", bus.valid_o, bus.ready_o);
    @(negedge clk_i) rst_n_i = 1'b1;
    bus.ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check($sformatf("flight.drain%0d", k), 32'(bus.valid_o), 32'd0);
    end

`ifdef ADDSUB_PRE_NORM_DAZ_EN
    daz_fract = 28'h0;
`else
    daz_fract = 28'h8;
`endif
    // smallest denormal + 0: fraction LSB lands at bit 3 unless flushed
    run_one("denorm", 32'h00000001, 32'h00000000, 1'b0, 2'b00, daz_fract, 8'h01, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
